// File: rtl/leds_hold_display_if.sv
// leds_hold_display_if
//   Bundles the result/strobe inputs and the LED/status outputs of
//   leds_hold_display.
//   master : producer side (multiplier control FSM or testbench)
//   slave  : the display stage
//   Signals: i_product[DW-1:0], i_sign, i_valid, i_clear  (master -> slave)
//            o_led[DW:0], o_ready, o_busy, o_accept        (slave -> master)
interface leds_hold_display_if #(
    parameter int DW = 16
);
    logic [DW-1:0] i_product;
    logic          i_sign;
    logic          i_valid;
    logic          i_clear;
    logic [DW:0]   o_led;
    logic          o_ready;
    logic          o_busy;
    logic          o_accept;

    modport master (
        output i_product, i_sign, i_valid, i_clear,
        input  o_led, o_ready, o_busy, o_accept
    );

    modport slave (
        input  i_product, i_sign, i_valid, i_clear,
        output o_led, o_ready, o_busy, o_accept
    );
endinterface

// File: rtl/leds_hold_display.sv
// leds_hold_display
//   Registered LED output stage for a signed multiplier result. A result
//   (magnitude + sign) is captured on i_valid, shown on o_led from the next
//   cycle, held for at least HOLD_CYCLES cycles (o_busy high, further strobes
//   dropped), then kept until cleared or overwritten.
//   Ports:
//     clk  - system clock, rising edge
//     rst  - asynchronous active-low reset
//     bus  - leds_hold_display_if.slave:
//            i_product/i_sign/i_valid/i_clear in,
//            o_led ([DW]=sign, [DW-1:0]=magnitude), o_ready, o_busy, o_accept out
//   Optional feature macro: LEDS_BLINK_EN
//     When defined, a negative result blinks its magnitude with half-period
//     BLINK_HALF cycles while displayed; the sign bit stays steady.
module leds_hold_display #(
    parameter int DW          = 16,
    parameter int HOLD_CYCLES = 8,
    parameter int BLINK_HALF  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    leds_hold_display_if.slave   bus
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    if (HOLD_CYCLES < 1 || BLINK_HALF < 1) begin : g_bad_param
        $error("leds_hold_display: HOLD_CYCLES and BLINK_HALF must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISPLAY = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] mag_q, mag_d;
    logic          sign_q, sign_d;
    logic          clr_q, clr_d;
    logic          accept_q, accept_d;
    logic          capture;
    logic          blank;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mag_d    = mag_q;
        sign_d   = sign_q;
        clr_d    = clr_q;
        accept_d = 1'b0;
        capture  = 1'b0;

        case (state_q)
            IDLE: begin
                capture = bus.i_valid;
            end
            DISPLAY: begin
                // A clear arriving in the final hold cycle still counts.
                clr_d = clr_q | bus.i_clear;
                if (cnt_q == '0) begin
                    clr_d = 1'b0;
                    if (clr_q | bus.i_clear) begin
                        state_d = IDLE;
                        mag_d   = '0;
                        sign_d  = 1'b0;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                // A simultaneous strobe wins over a clear.
                capture = bus.i_valid;
                if (!bus.i_valid && bus.i_clear) begin
                    state_d = IDLE;
                    mag_d   = '0;
                    sign_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                mag_d   = '0;
                sign_d  = 1'b0;
                cnt_d   = '0;
                clr_d   = 1'b0;
            end
        endcase

        if (capture) begin
            state_d  = DISPLAY;
            mag_d    = bus.i_product;
            sign_d   = bus.i_sign;
            cnt_d    = CW'(HOLD_CYCLES - 1);
            clr_d    = 1'b0;
            accept_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mag_q    <= '0;
            sign_q   <= 1'b0;
            clr_q    <= 1'b0;
            accept_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mag_q    <= mag_d;
            sign_q   <= sign_d;
            clr_q    <= clr_d;
            accept_q <= accept_d;
        end
    end

`ifdef LEDS_BLINK_EN
    localparam int BW = $clog2(2 * BLINK_HALF);

    logic [BW-1:0] blink_q, blink_d;

    // Phase counter runs 0 .. 2*BLINK_HALF-1; the first half is the "on" phase.
    always_comb begin
        blink_d = blink_q;
        if (capture || state_d == IDLE) begin
            blink_d = '0;
        end else if (blink_q == BW'(2 * BLINK_HALF - 1)) begin
            blink_d = '0;
        end else begin
            blink_d = blink_q + BW'(1);
        end
        blank = sign_q && (state_q != IDLE) && (blink_q >= BW'(BLINK_HALF));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_d;
        end
    end
`else
    assign blank = 1'b0;
`endif

    assign bus.o_led    = {sign_q, (blank ? {DW{1'b0}} : mag_q)};
    assign bus.o_ready  = (state_q != IDLE);
    assign bus.o_busy   = (state_q == DISPLAY);
    assign bus.o_accept = accept_q;
endmodule

// File: tb/tb_leds_hold_display.sv
// tb_leds_hold_display
//   Directed bench for leds_hold_display. dut0 uses HOLD_CYCLES=4,
//   BLINK_HALF=2; dut1 uses HOLD_CYCLES=1. Expected output vectors are
//   queued as stimulus is driven and compared one cycle later.
module tb_leds_hold_display;
    localparam int DW         = 16;
    localparam int BLINK_HALF = 2;
    localparam bit BLINK =
`ifdef LEDS_BLINK_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct {
        string       tag;
        int          dut;
        logic [DW:0] led;
        logic        ready;
        logic        busy;
        logic        accept;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    leds_hold_display_if #(.DW(DW)) bus0 ();
    leds_hold_display_if #(.DW(DW)) bus1 ();

    leds_hold_display #(.DW(DW), .HOLD_CYCLES(4), .BLINK_HALF(BLINK_HALF)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    leds_hold_display #(.DW(DW), .HOLD_CYCLES(1), .BLINK_HALF(BLINK_HALF)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    // Displayed value k cycles after capture.
    function automatic logic [DW:0] led_at(logic [DW-1:0] mag, logic sign, int k);
        logic [DW-1:0] m;
        m = mag;
        if (BLINK && sign && ((k / BLINK_HALF) % 2 == 1)) m = '0;
        return {sign, m};
    endfunction

    task automatic push(string tag, int dut, logic [DW:0] led, logic r, logic b, logic a);
        exp_t e;
        e.tag = tag; e.dut = dut; e.led = led; e.ready = r; e.busy = b; e.accept = a;
        sb.push_back(e);
    endtask

    task automatic compare_all();
        exp_t        e;
        logic [DW+3:0] obs, exp_v;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) obs = {bus0.o_led, bus0.o_ready, bus0.o_busy, bus0.o_accept};
            else            obs = {bus1.o_led, bus1.o_ready, bus1.o_busy, bus1.o_accept};
            exp_v = {e.led, e.ready, e.busy, e.accept};
            vectors++;
            assert (obs === exp_v) else begin
                miscompares++;
                $error("FAIL %s (dut%0d): observed led=%h rdy/busy/acc=%b expected led=%h rdy/busy/acc=%b",
                       e.tag, e.dut, obs[DW+3:3], obs[2:0], exp_v[DW+3:3], exp_v[2:0]);
            end
        end
    endtask

    task automatic step(string tag, logic [DW:0] led, logic r, logic b, logic a);
        push(tag, 0, led, r, b, a);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic step1(string tag, logic [DW:0] led, logic r, logic b, logic a);
        push(tag, 1, led, r, b, a);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive0(logic [DW-1:0] p, logic s, logic v, logic c);
        bus0.i_product = p; bus0.i_sign = s; bus0.i_valid = v; bus0.i_clear = c;
    endtask

    initial begin
        logic [DW-1:0] vals [3];
        vals[0] = 16'h0001; vals[1] = 16'hBEEF; vals[2] = 16'h7FFF;

        drive0('0, 1'b0, 1'b0, 1'b0);
        bus1.i_product = '0; bus1.i_sign = 1'b0; bus1.i_valid = 1'b0; bus1.i_clear = 1'b0;

        // Reset state
        #3;
        push("reset0", 0, '0, 0, 0, 0);
        push("reset1", 1, '0, 0, 0, 0);
        compare_all();
        @(posedge clk);
        #1 rst = 1'b1;
        step("idle", '0, 0, 0, 0);

        // Basic capture: 4 busy cycles then HOLD
        drive0(16'h1234, 1'b0, 1'b1, 1'b0);
        step("cap_1234", 17'h01234, 1, 1, 1);
        drive0(16'h1234, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) step("disp_1234", 17'h01234, 1, 1, 0);
        for (int k = 4; k <= 5; k++) step("hold_1234", 17'h01234, 1, 0, 0);

        // Clear in HOLD blanks next cycle
        drive0(16'h0000, 1'b0, 1'b0, 1'b1);
        step("hold_clear", '0, 0, 0, 0);
        drive0(16'h0000, 1'b0, 1'b0, 1'b0);

        // Strobe during DISPLAY is dropped
        drive0(16'h00AA, 1'b0, 1'b1, 1'b0);
        step("cap_00aa", 17'h000AA, 1, 1, 1);
        drive0(16'h00AA, 1'b0, 1'b0, 1'b0);
        step("disp_00aa", 17'h000AA, 1, 1, 0);
        drive0(16'h5555, 1'b0, 1'b1, 1'b0);
        step("busy_drop", 17'h000AA, 1, 1, 0);
        drive0(16'h5555, 1'b0, 1'b0, 1'b0);
        step("disp_00aa_end", 17'h000AA, 1, 1, 0);
        step("hold_00aa", 17'h000AA, 1, 0, 0);

        // Recapture from HOLD, negative; clear during DISPLAY
        drive0(16'h5555, 1'b1, 1'b1, 1'b0);
        step("recap_15555", led_at(16'h5555, 1'b1, 0), 1, 1, 1);
        drive0(16'h5555, 1'b1, 1'b0, 1'b1);
        step("disp_clr_set", led_at(16'h5555, 1'b1, 1), 1, 1, 0);
        drive0(16'h5555, 1'b1, 1'b0, 1'b0);
        for (int k = 2; k <= 3; k++) step("disp_clr_pend", led_at(16'h5555, 1'b1, k), 1, 1, 0);
        step("disp_clr_done", '0, 0, 0, 0);
        step("idle_after_clr", '0, 0, 0, 0);

        // Valid and clear together in HOLD: valid wins
        drive0(16'h0777, 1'b0, 1'b1, 1'b0);
        step("cap_0777", 17'h00777, 1, 1, 1);
        drive0(16'h0777, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) step("disp_0777", 17'h00777, 1, 1, 0);
        step("hold_0777", 17'h00777, 1, 0, 0);
        drive0(16'h0ABC, 1'b0, 1'b1, 1'b1);
        step("valid_wins", 17'h00ABC, 1, 1, 1);
        drive0(16'h0ABC, 1'b0, 1'b0, 1'b0);
        step("disp_0abc", 17'h00ABC, 1, 1, 0);

        // Asynchronous reset mid-DISPLAY
        #2 rst = 1'b0;
        #1;
        push("async_rst", 0, '0, 0, 0, 0);
        compare_all();
        step("rst_held", '0, 0, 0, 0);
        rst = 1'b1;
        step("after_rst", '0, 0, 0, 0);
        drive0(16'hFFFF, 1'b1, 1'b1, 1'b0);
        step("cap_1ffff", led_at(16'hFFFF, 1'b1, 0), 1, 1, 1);
        drive0(16'hFFFF, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) step("disp_1ffff", led_at(16'hFFFF, 1'b1, k), 1, 1, 0);
        for (int k = 4; k <= 5; k++) step("hold_1ffff", led_at(16'hFFFF, 1'b1, k), 1, 0, 0);
        drive0(16'h0000, 1'b0, 1'b0, 1'b1);
        step("clr_1ffff", '0, 0, 0, 0);

        // Negative result (blinks when the feature is built in), then positive recapture
        drive0(16'h0F0F, 1'b1, 1'b1, 1'b0);
        step("cap_neg_0f0f", led_at(16'h0F0F, 1'b1, 0), 1, 1, 1);
        drive0(16'h0F0F, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) step("neg_disp", led_at(16'h0F0F, 1'b1, k), 1, 1, 0);
        for (int k = 4; k <= 7; k++) step("neg_hold", led_at(16'h0F0F, 1'b1, k), 1, 0, 0);
        drive0(16'h0F0F, 1'b0, 1'b1, 1'b0);
        step("cap_pos_0f0f", 17'h00F0F, 1, 1, 1);
        drive0(16'h0F0F, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) step("pos_disp", 17'h00F0F, 1, 1, 0);
        for (int k = 4; k <= 6; k++) step("pos_hold", 17'h00F0F, 1, 0, 0);
        drive0(16'h0000, 1'b0, 1'b0, 1'b1);
        step("clr_pos", '0, 0, 0, 0);
        drive0(16'h0000, 1'b0, 1'b0, 1'b0);

        // HOLD_CYCLES=1: strobe every 2 cycles, each accepted, busy for one cycle
        for (int i = 0; i < 3; i++) begin
            bus1.i_product = vals[i]; bus1.i_sign = 1'b0; bus1.i_valid = 1'b1;
            step1("h1_cap", {1'b0, vals[i]}, 1, 1, 1);
            bus1.i_valid = 1'b0;
            step1("h1_hold", {1'b0, vals[i]}, 1, 0, 0);
        end
        bus1.i_clear = 1'b1;
        step1("h1_clear", '0, 0, 0, 0);
        bus1.i_clear = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
